// File: rtl/mem_burst_ctrl_pkg.sv
// Shared definitions for the page-mapped burst memory controller.
// Optional protocol checking in mem_burst_ctrl is enabled by defining MEMCTRL_PROTO_CHK_EN.
package mcDefs;
    localparam int BUSWIDTH        = 16;
    localparam int ADDRWIDTH       = 12;
    localparam int DATAPAYLOADSIZE = 4;
    localparam int BEATWIDTH       = 3;
    localparam logic [3:0] VALID_PAGE = 4'h2;

    typedef enum logic [2:0] {IDLE, WR, RD_TURN, RD, SKIP} burst_state_t;
    typedef logic [ADDRWIDTH-1:0] word_addr_t;
    typedef logic [BUSWIDTH-1:0]  bus_word_t;
    typedef logic [BEATWIDTH-1:0] beat_t;
endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Main-bus and memory-array signals seen by the burst controller.
interface mem_burst_ctrl_if;
    import mcDefs::*;

    logic       AddrValid;
    logic       rw;
    bus_word_t  AddrData_in;
    bus_word_t  AddrData_out;
    logic       AddrData_oe;
    word_addr_t mem_addr;
    bus_word_t  mem_wdata;
    logic       mem_we;
    bus_word_t  mem_rdata;

    modport slave (
        input  AddrValid, rw, AddrData_in, mem_rdata,
        output AddrData_out, AddrData_oe, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output AddrValid, rw, AddrData_in, mem_rdata,
        input  AddrData_out, AddrData_oe, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_burst_ctrl_addr_gen.sv
// Burst address generator: holds the base word address and the beat counter,
// producing the current and next (prefetch) addresses with modulo-page wrap.
module mem_addr_gen
    import mcDefs::*;
(
    input  logic       clk,
    input  logic       resetH,
    input  logic       load,
    input  logic       advance,
    input  word_addr_t baseIn,
    output word_addr_t addr,
    output word_addr_t addrNext,
    output beat_t      beat,
    output logic       last
);
    word_addr_t base;

    always_ff @(posedge clk) begin
        if (resetH) begin
            base <= '0;
            beat <= '0;
        end else if (load) begin
            base <= baseIn;
            beat <= '0;
        end else if (advance) begin
            beat <= beat + beat_t'(1);
        end
    end

    // Carry out of the word address is dropped so bursts wrap inside the page.
    assign addr     = base + word_addr_t'(beat);
    assign addrNext = addr + word_addr_t'(1);
    assign last     = (beat == beat_t'(DATAPAYLOADSIZE - 1));
endmodule

// File: rtl/mem_burst_ctrl.sv
// Bus-side burst controller: decodes the address beat, runs 4-beat write/read bursts
// to page PAGE and silently tracks bursts to other pages. Define MEMCTRL_PROTO_CHK_EN for proto_err.
module mem_burst_ctrl
    import mcDefs::*;
#(
    parameter logic [3:0] PAGE = VALID_PAGE
) (
    input  logic              clk,
    input  logic              resetH,
    mem_burst_ctrl_if.slave   bus
`ifdef MEMCTRL_PROTO_CHK_EN
    ,
    output logic              proto_err
`endif
);
    burst_state_t state, stateNext;
    logic         burstRead;
    logic         load, advance, hit;
    logic         memWe, oe;
    word_addr_t   memAddr, lastAddr, addr, addrNext;
    beat_t        beat;
    logic         last;

    mem_addr_gen addrGen (
        .clk      (clk),
        .resetH   (resetH),
        .load     (load),
        .advance  (advance),
        .baseIn   (bus.AddrData_in[ADDRWIDTH-1:0]),
        .addr     (addr),
        .addrNext (addrNext),
        .beat     (beat),
        .last     (last)
    );

    assign hit = (bus.AddrData_in[15:12] == PAGE);

    always_ff @(posedge clk) begin
        if (resetH) begin
            state     <= IDLE;
            burstRead <= 1'b0;
            lastAddr  <= '0;
        end else begin
            state    <= stateNext;
            lastAddr <= memAddr;
            if (load)
                burstRead <= bus.rw;
        end
    end

    // Read bursts present mem_addr one beat ahead to cover the registered memory latency.
    always_comb begin
        stateNext = state;
        load      = 1'b0;
        advance   = 1'b0;
        memAddr   = lastAddr;
        memWe     = 1'b0;
        oe        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.AddrValid) begin
                    load = 1'b1;
                    if (!hit)
                        stateNext = SKIP;
                    else if (bus.rw)
                        stateNext = RD_TURN;
                    else
                        stateNext = WR;
                end
            end
            WR: begin
                advance = 1'b1;
                memWe   = 1'b1;
                memAddr = addr;
                if (last)
                    stateNext = IDLE;
            end
            RD_TURN: begin
                memAddr   = addr;
                stateNext = RD;
            end
            RD: begin
                advance = 1'b1;
                oe      = 1'b1;
                if (last)
                    stateNext = IDLE;
                else
                    memAddr = addrNext;
            end
            SKIP: begin
                advance = 1'b1;
                if (beat == beat_t'(burstRead ? DATAPAYLOADSIZE : DATAPAYLOADSIZE - 1))
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Strobes are gated by reset so an aborted burst drives nothing in the reset cycle.
    assign bus.mem_we       = memWe & ~resetH;
    assign bus.mem_wdata    = (memWe & ~resetH) ? bus.AddrData_in : '0;
    assign bus.mem_addr     = memAddr;
    assign bus.AddrData_oe  = oe & ~resetH;
    assign bus.AddrData_out = (oe & ~resetH) ? bus.mem_rdata : '0;

`ifdef MEMCTRL_PROTO_CHK_EN
    assign proto_err = bus.AddrValid && (state != IDLE) && !resetH;

    always_ff @(posedge clk) begin
        if (!resetH)
            assert (!(bus.AddrValid && state != IDLE))
                else $error("mem_burst_ctrl: AddrValid while burst in progress");
    end
`endif
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed self-checking bench for mem_burst_ctrl with a registered-read memory model.
// Build with MEMCTRL_PROTO_CHK_EN to also check the proto_err pulse.
module tb_mem_burst_ctrl;
    logic clk = 1'b0;
    logic resetH;
    logic memInit;
    int   testsRun = 0;
    int   failCount = 0;

    mem_burst_ctrl_if bus();

`ifdef MEMCTRL_PROTO_CHK_EN
    logic proto_err;
`endif

    mem_burst_ctrl dut (
        .clk    (clk),
        .resetH (resetH),
        .bus    (bus.slave)
`ifdef MEMCTRL_PROTO_CHK_EN
        ,
        .proto_err (proto_err)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous memory: write on mem_we, read data one cycle after mem_addr.
    logic [15:0] mem [0:4095];
    logic [15:0] rdataQ;
    assign bus.mem_rdata = rdataQ;

    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 4096; i++)
                mem[i] <= 16'(i) ^ 16'hA5A5;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        rdataQ <= mem[bus.mem_addr];
    end

    logic [15:0] pat1  [4];
    logic [11:0] addr1 [4];
    logic [15:0] exp3  [4];
    logic [15:0] pat6  [4];

    task automatic applyStimulus(input logic rst, input logic av, input logic rwv, input logic [15:0] d);
        @(posedge clk);
        #1;
        resetH          = rst;
        bus.AddrValid   = av;
        bus.rw          = rwv;
        bus.AddrData_in = d;
        #3;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
            else begin
                failCount++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            end
    endtask

    initial begin
        pat1  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        addr1 = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        exp3  = '{16'hAAA5, 16'hAAA4, 16'hAAA7, 16'hAAA6};
        pat6  = '{16'h5A01, 16'h5A02, 16'h5A03, 16'h5A04};

        memInit         = 1'b1;
        resetH          = 1'b1;
        bus.AddrValid   = 1'b0;
        bus.rw          = 1'b0;
        bus.AddrData_in = '0;

        // Reset and post-reset idle outputs
        applyStimulus(1, 0, 0, 16'h0000);
        memInit = 1'b0;
        applyStimulus(1, 0, 0, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("rstWe",   bus.mem_we,       0);
        checkOutput("rstOe",   bus.AddrData_oe,  0);
        checkOutput("rstOut",  bus.AddrData_out, 0);
        checkOutput("rstAddr", bus.mem_addr,     0);

        // Test 1: wrapping write burst to page 2 base 0xFFE
        applyStimulus(0, 1, 0, 16'h2FFE);
        checkOutput("t1AddrBeatWe", bus.mem_we, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, pat1[i]);
            checkOutput("t1We",    bus.mem_we,    1);
            checkOutput("t1Addr",  bus.mem_addr,  addr1[i]);
            checkOutput("t1Wdata", bus.mem_wdata, pat1[i]);
        end
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t1EndWe", bus.mem_we, 0);
        checkOutput("t1MemFFE", mem[12'hFFE], 16'h1111);
        checkOutput("t1MemFFF", mem[12'hFFF], 16'h2222);
        checkOutput("t1Mem000", mem[12'h000], 16'h3333);
        checkOutput("t1Mem001", mem[12'h001], 16'h4444);

        // Test 2: read back across the wrap
        applyStimulus(0, 1, 1, 16'h2FFE);
        checkOutput("t2AddrBeatOe", bus.AddrData_oe, 0);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t2TurnOe",   bus.AddrData_oe, 0);
        checkOutput("t2TurnAddr", bus.mem_addr,    12'hFFE);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 16'h0000);
            checkOutput("t2Oe",  bus.AddrData_oe,  1);
            checkOutput("t2Out", bus.AddrData_out, pat1[i]);
            if (i < 3)
                checkOutput("t2Prefetch", bus.mem_addr, addr1[i+1]);
        end
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t2EndOe", bus.AddrData_oe, 0);

        // Test 3: write to page 0 is skipped, then read page 2 on first idle cycle
        applyStimulus(0, 1, 0, 16'h0F00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 16'hFFFF);
            checkOutput("t3SkipWe", bus.mem_we,      0);
            checkOutput("t3SkipOe", bus.AddrData_oe, 0);
        end
        applyStimulus(0, 1, 1, 16'h2F00);
        checkOutput("t3IdleWe", bus.mem_we, 0);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t3TurnOe", bus.AddrData_oe, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 16'h0000);
            checkOutput("t3Oe",  bus.AddrData_oe,  1);
            checkOutput("t3Out", bus.AddrData_out, exp3[i]);
        end
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t3EndOe", bus.AddrData_oe, 0);

        // Skipped read lasts 5 cycles; AddrValid on its last beat is ignored
        applyStimulus(0, 1, 1, 16'h5123);
        for (int i = 0; i < 5; i++) begin
            if (i == 4)
                applyStimulus(0, 1, 0, 16'h2100);
            else
                applyStimulus(0, 0, 0, 16'h0000);
            checkOutput("t3bSkipWe", bus.mem_we,      0);
            checkOutput("t3bSkipOe", bus.AddrData_oe, 0);
        end
        applyStimulus(0, 0, 0, 16'h7777);
        checkOutput("t3bLastBeatIgnored", bus.mem_we, 0);

        // Test 4: reset during write beat 2 aborts the burst
        applyStimulus(0, 1, 0, 16'h2200);
        applyStimulus(0, 0, 0, 16'hAAAA);
        checkOutput("t4Beat0We", bus.mem_we, 1);
        applyStimulus(0, 0, 0, 16'hBBBB);
        checkOutput("t4Beat1We", bus.mem_we, 1);
        applyStimulus(1, 0, 0, 16'hCCCC);
        checkOutput("t4RstWe", bus.mem_we, 0);

        // Test 5: read issued on the first cycle after reset, spurious AddrValid on beat 1
        applyStimulus(0, 1, 1, 16'h2200);
        checkOutput("t4PostRstWe",   bus.mem_we,   0);
        checkOutput("t4PostRstAddr", bus.mem_addr, 0);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t5TurnAddr", bus.mem_addr,    12'h200);
        checkOutput("t5TurnOe",   bus.AddrData_oe, 0);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t5Beat0", bus.AddrData_out, 16'hAAAA);
        applyStimulus(0, 1, 0, 16'h2FFE);
        checkOutput("t5Beat1",   bus.AddrData_out, 16'hBBBB);
        checkOutput("t5Beat1Oe", bus.AddrData_oe,  1);
        checkOutput("t5Beat1We", bus.mem_we,       0);
`ifdef MEMCTRL_PROTO_CHK_EN
        checkOutput("t5ProtoErr", proto_err, 1);
`endif
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t5Beat2", bus.AddrData_out, 16'hA7A7);
`ifdef MEMCTRL_PROTO_CHK_EN
        checkOutput("t5ProtoErrClr", proto_err, 0);
`endif
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t5Beat3", bus.AddrData_out, 16'hA7A6);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t5EndOe", bus.AddrData_oe, 0);
        checkOutput("t4Mem200", mem[12'h200], 16'hAAAA);
        checkOutput("t4Mem201", mem[12'h201], 16'hBBBB);
        checkOutput("t4Mem202", mem[12'h202], 16'hA7A7);
        checkOutput("t4Mem203", mem[12'h203], 16'hA7A6);
        checkOutput("t5MemFFE", mem[12'hFFE], 16'h1111);

        // Test 6: back-to-back write then read at page 2 base 0x010
        applyStimulus(0, 1, 0, 16'h2010);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, pat6[i]);
            checkOutput("t6We", bus.mem_we, 1);
        end
        applyStimulus(0, 1, 1, 16'h2010);
        checkOutput("t6IdleWe", bus.mem_we, 0);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t6TurnAddr", bus.mem_addr,    12'h010);
        checkOutput("t6TurnOe",   bus.AddrData_oe, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 16'h0000);
            checkOutput("t6Oe",  bus.AddrData_oe,  1);
            checkOutput("t6Out", bus.AddrData_out, pat6[i]);
        end
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t6EndOe", bus.AddrData_oe, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
